// File: rtl/cram_opb_arbiter.sv
// cram_opb_arbiter: two-requester round-robin arbiter in front of a single OPB PSRAM port.
// Requester A (bit 0) is the CD sector path, requester B (bit 1) the CPU/ADPCM path.
// Optional watchdog: define CRAM_ARB_TIMEOUT_EN to add the XFER timeout counter and err port.
module cram_opb_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  rnw,
    input  logic [1:0]  is32,
    input  logic [47:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [1:0]  ack,
    output logic [15:0] rdata,
    output logic [23:0] OPB_ABus,
    output logic [1:0]  OPB_BE,
    output logic [15:0] OPB_DBus,
    output logic        OPB_RNW,
    output logic        OPB_32Bit,
    output logic        OPB_select,
    input  logic [15:0] Sln_DBus,
    input  logic        Sln_xferAck
`ifdef CRAM_ARB_TIMEOUT_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [1:0] {StIdle, StXfer, StRelease} state_t;

    state_t state, state_next;
    logic   grant;          // last granted requester: 0 = A, 1 = B
    logic   grant_next;
    logic   load;           // latch the winner's request this edge
    logic   done;           // transfer completes this edge (slave ack or watchdog)
    logic   timeout_hit;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

`ifdef CRAM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] tcnt;

    // Watchdog: counts cycles spent in XFER, cleared when a new grant is loaded.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            tcnt <= '0;
        end else if (load) begin
            tcnt <= '0;
        end else if (state == StXfer) begin
            tcnt <= tcnt + CntW'(1);
        end
    end

    assign timeout_hit = (state == StXfer) && (tcnt == CntW'(TIMEOUT_CYC - 1));

    // Sticky error: set only when the watchdog, not the slave, ended the transfer.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            err <= 1'b0;
        end else if (done && !Sln_xferAck) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign done       = (state == StXfer) && (Sln_xferAck || timeout_hit);
    assign OPB_select = (state == StXfer);

    // Next-state and arbitration; req is only looked at in IDLE.
    always_comb begin
        state_next = state;
        grant_next = grant;
        load       = 1'b0;
        unique case (state)
            StIdle: begin
                if (req != 2'b00) begin
                    load       = 1'b1;
                    // Tie goes to whoever did not win last time.
                    grant_next = (req == 2'b11) ? ~grant : req[1];
                    state_next = StXfer;
                end
            end
            StXfer: begin
                if (done) begin
                    state_next = StRelease;
                end
            end
            StRelease: begin
                state_next = StIdle;
            end
            default: begin
                state_next = StIdle;
            end
        endcase
    end

    // State and grant registers; reset leaves B as last grant so A wins the first tie.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state <= StIdle;
            grant <= 1'b1;
        end else begin
            state <= state_next;
            grant <= grant_next;
        end
    end

    // OPB request registers: loaded once per grant, held steady through XFER.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            OPB_ABus  <= '0;
            OPB_BE    <= '0;
            OPB_DBus  <= '0;
            OPB_RNW   <= 1'b1;
            OPB_32Bit <= 1'b0;
        end else if (load) begin
            OPB_ABus  <= grant_next ? addr[47:24]  : addr[23:0];
            OPB_BE    <= grant_next ? be[3:2]      : be[1:0];
            OPB_DBus  <= grant_next ? wdata[31:16] : wdata[15:0];
            OPB_RNW   <= grant_next ? rnw[1]       : rnw[0];
            OPB_32Bit <= grant_next ? is32[1]      : is32[0];
        end
    end

    // Completion: one-cycle ack to the granted requester, read data captured at the same edge.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            ack   <= 2'b00;
            rdata <= '0;
        end else begin
            ack <= 2'b00;
            if (done) begin
                ack   <= grant ? 2'b10 : 2'b01;
                rdata <= Sln_xferAck ? Sln_DBus : 16'hDEAD;
            end
        end
    end

endmodule

// File: tb/tb_cram_opb_arbiter.sv
// Self-checking bench for cram_opb_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with literal expectations. Timeout scenario needs CRAM_ARB_TIMEOUT_EN.
module tb_cram_opb_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  rnw = '0;
    logic [1:0]  is32 = '0;
    logic [47:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  ack;
    logic [15:0] rdata;
    logic [23:0] OPB_ABus;
    logic [1:0]  OPB_BE;
    logic [15:0] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_32Bit;
    logic        OPB_select;
    logic [15:0] Sln_DBus = '0;
    logic        Sln_xferAck = 1'b0;
`ifdef CRAM_ARB_TIMEOUT_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    // Slave behaviour knobs
    int          slave_delay = 1000;
    logic [15:0] slave_data = '0;
    bit          stray = 0;
    int          sel_cnt = 0;

    cram_opb_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .OPB_Clk     (clk),
        .OPB_Rst_n   (rst_n),
        .req         (req),
        .rnw         (rnw),
        .is32        (is32),
        .addr        (addr),
        .be          (be),
        .wdata       (wdata),
        .ack         (ack),
        .rdata       (rdata),
        .OPB_ABus    (OPB_ABus),
        .OPB_BE      (OPB_BE),
        .OPB_DBus    (OPB_DBus),
        .OPB_RNW     (OPB_RNW),
        .OPB_32Bit   (OPB_32Bit),
        .OPB_select  (OPB_select),
        .Sln_DBus    (Sln_DBus),
        .Sln_xferAck (Sln_xferAck)
`ifdef CRAM_ARB_TIMEOUT_EN
        ,
        .err         (err)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: acks in the slave_delay-th cycle that select is high; can also drive stray acks.
    initial forever begin
        @(posedge clk);
        #1;
        Sln_DBus = slave_data;
        if (OPB_select) begin
            sel_cnt++;
            Sln_xferAck = (sel_cnt == slave_delay);
        end else begin
            sel_cnt = 0;
            Sln_xferAck = stray;
        end
    end

    // ---------------- behavioural model ----------------
    logic        m_sel, m_rel, m_last, m_fin, m_to, m_pick;
    logic [1:0]  m_ack;
    logic [15:0] m_rdata, m_dbus;
    logic [23:0] m_abus;
    logic [1:0]  m_be;
    logic        m_rnw, m_32;
`ifdef CRAM_ARB_TIMEOUT_EN
    int          m_age;
    logic        m_err;
`endif

    always_comb begin
        m_to = 1'b0;
`ifdef CRAM_ARB_TIMEOUT_EN
        m_to = (m_age + 1 == TO);
`endif
        m_fin  = m_sel && (Sln_xferAck || m_to);
        m_pick = (req == 2'b11) ? ~m_last : req[1];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sel <= 0; m_rel <= 0; m_last <= 1; m_ack <= 0; m_rdata <= 0;
            m_abus <= 0; m_be <= 0; m_dbus <= 0; m_rnw <= 1; m_32 <= 0;
`ifdef CRAM_ARB_TIMEOUT_EN
            m_age <= 0; m_err <= 0;
`endif
        end else begin
            m_ack <= 2'b00;
            if (m_sel) begin
`ifdef CRAM_ARB_TIMEOUT_EN
                m_age <= m_age + 1;
                if (m_fin && !Sln_xferAck) m_err <= 1;
`endif
                if (m_fin) begin
                    m_sel   <= 0;
                    m_rel   <= 1;
                    m_ack   <= m_last ? 2'b10 : 2'b01;
                    m_rdata <= Sln_xferAck ? Sln_DBus : 16'hDEAD;
                end
            end else if (m_rel) begin
                m_rel <= 0;
            end else if (req != 2'b00) begin
                m_sel  <= 1;
                m_last <= m_pick;
                m_abus <= addr[24*m_pick +: 24];
                m_be   <= be[2*m_pick +: 2];
                m_dbus <= wdata[16*m_pick +: 16];
                m_rnw  <= rnw[m_pick];
                m_32   <= is32[m_pick];
`ifdef CRAM_ARB_TIMEOUT_EN
                m_age  <= 0;
`endif
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("select", 32'(OPB_select), 32'(m_sel));
            check("ack", 32'(ack), 32'(m_ack));
            check("rdata", 32'(rdata), 32'(m_rdata));
            check("abus", 32'(OPB_ABus), 32'(m_abus));
            check("be", 32'(OPB_BE), 32'(m_be));
            check("dbus", 32'(OPB_DBus), 32'(m_dbus));
            check("rnw", 32'(OPB_RNW), 32'(m_rnw));
            check("is32", 32'(OPB_32Bit), 32'(m_32));
            check("ack_onehot", 32'(ack == 2'b11), 32'd0);
`ifdef CRAM_ARB_TIMEOUT_EN
            check("err", 32'(err), 32'(m_err));
`endif
        end
    end

    // Waits for a DUT ack, counting select-high cycles and select-low cycles before the grant.
    task automatic wait_ack(input int budget, output logic [1:0] a, output logic [15:0] rd,
                            output int nsel, output int lead);
        bit got = 0;
        bit seen = 0;
        a = '0; rd = '0; nsel = 0; lead = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (OPB_select) begin
                nsel++;
                seen = 1;
            end else if (!seen) begin
                lead++;
            end
            if (ack != 2'b00) begin
                got = 1;
                a = ack;
                rd = rdata;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_wait: got no ack expected ack within %0d cycles", budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    logic [1:0]  a;
    logic [15:0] rd;
    int          nsel, lead;
    logic [1:0]  exp_order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1;
        cmp_en = 1;
        check("rst_select", 32'(OPB_select), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_abus", 32'(OPB_ABus), 32'd0);
        check("rst_rnw", 32'(OPB_RNW), 32'd1);
        check("rst_is32", 32'(OPB_32Bit), 32'd0);

        // A-only read, slave acks after 4 cycles
        slave_delay = 4; slave_data = 16'hBEEF;
        addr = 48'h000000_000123; rnw = 2'b11; be = 4'b0000;
        req = 2'b01;
        wait_ack(30, a, rd, nsel, lead);
        req = 2'b00;
        check("t1_sel_cycles", 32'(nsel), 32'd4);
        check("t1_ack", 32'(a), 32'h1);
        check("t1_rdata", 32'(rd), 32'hBEEF);
        repeat (2) @(negedge clk);

        // B 32-bit write: fields must be steady for the whole select window
        slave_delay = 3; slave_data = 16'h5555;
        addr = {24'h3FFFFE, 24'h000111}; be = 4'b1000; wdata = 32'h1234_0000;
        is32 = 2'b10; rnw = 2'b01;
        req = 2'b10;
        begin
            bit done_w = 0;
            int nwin = 0;
            for (int i = 0; i < 30 && !done_w; i++) begin
                @(negedge clk);
                if (OPB_select) begin
                    nwin++;
                    check("t3_abus", 32'(OPB_ABus), 32'h3FFFFE);
                    check("t3_be", 32'(OPB_BE), 32'h2);
                    check("t3_dbus", 32'(OPB_DBus), 32'h1234);
                    check("t3_is32", 32'(OPB_32Bit), 32'd1);
                    check("t3_rnw", 32'(OPB_RNW), 32'd0);
                end
                if (ack != 2'b00) begin
                    done_w = 1;
                    check("t3_ack", 32'(ack), 32'h2);
                end
            end
            req = 2'b00;
            check("t3_done", 32'(done_w), 32'd1);
            check("t3_window", 32'(nwin), 32'd3);
        end
        repeat (2) @(negedge clk);

        // Tie after reset: A,B,A,B with select low between grants
        do_reset();
        slave_delay = 2; slave_data = 16'h0C0C;
        addr = {24'h000BBB, 24'h000AAA}; rnw = 2'b11; is32 = 2'b00;
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_ack(30, a, rd, nsel, lead);
            if (g == 3) req = 2'b00;
            check("t2_order", 32'(a), 32'(exp_order[g]));
            check("t2_sel_cycles", 32'(nsel), 32'd2);
            if (g > 0) check("t2_gap", 32'(lead >= 1), 32'd1);
        end
        repeat (3) @(negedge clk);

        // Stray slave ack while idle
        stray = 1;
        repeat (3) begin
            @(negedge clk);
            check("stray_ack", 32'(ack), 32'd0);
            check("stray_select", 32'(OPB_select), 32'd0);
        end
        stray = 0;
        repeat (2) @(negedge clk);

        // Requester drops req right after grant: transfer still completes
        slave_delay = 3; slave_data = 16'h7777;
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        wait_ack(30, a, rd, nsel, lead);
        check("early_drop_ack", 32'(a), 32'h1);
        check("early_drop_rdata", 32'(rd), 32'h7777);
        repeat (3) @(negedge clk);

        // Reset two cycles into XFER; next tie must go to A
        slave_delay = 1000;
        req = 2'b10;
        @(negedge clk);
        check("t4_select_up", 32'(OPB_select), 32'd1);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("t4_async_select", 32'(OPB_select), 32'd0);
        check("t4_async_ack", 32'(ack), 32'd0);
        check("t4_async_rnw", 32'(OPB_RNW), 32'd1);
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1;
        slave_delay = 2;
        req = 2'b11;
        wait_ack(30, a, rd, nsel, lead);
        req = 2'b00;
        check("t4_first_tie", 32'(a), 32'h1);
        repeat (3) @(negedge clk);

`ifdef CRAM_ARB_TIMEOUT_EN
        // Watchdog: slave never acks
        do_reset();
        slave_delay = 1000;
        req = 2'b01;
        wait_ack(40, a, rd, nsel, lead);
        req = 2'b00;
        check("to_sel_cycles", 32'(nsel), 32'(TO));
        check("to_ack", 32'(a), 32'h1);
        check("to_rdata", 32'(rd), 32'hDEAD);
        repeat (5) @(negedge clk);
        check("to_err_sticky", 32'(err), 32'd1);
        do_reset();
        @(negedge clk);
        check("to_err_cleared", 32'(err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "simulation time limit");
    end

endmodule
